// File: rtl/bla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bla_pkg
// Brief    : Shared state encoding and default geometry for burst_line_adaptor.
// Revision : 1.0
// ============================================================================
package bla_pkg;

    localparam int DEF_LINE_W  = 256;
    localparam int DEF_BURST_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } bla_state_e;

endpackage
`default_nettype wire

// File: rtl/bla_beat_ctr.sv
`default_nettype none
// ============================================================================
// Module   : bla_beat_ctr
// Brief    : Beat slot index (loadable start, wraps modulo BEATS) plus a
//            separate completed-beat count driving the terminal flag.
// Revision : 1.0
// ============================================================================
module bla_beat_ctr #(
    parameter int BEATS = 4,
    parameter int IDX_W = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W-1:0] start_idx,
    input  logic             advance,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_cnt;

    // Slot index and beat count are kept apart so a wrapped start still
    // terminates after exactly BEATS acknowledged beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_idx <= start_idx;
            r_cnt <= '0;
        end else if (advance) begin
            r_idx <= r_idx + IDX_W'(1);
            r_cnt <= r_cnt + IDX_W'(1);
        end
    end

    assign idx  = r_idx;
    assign last = (r_cnt == IDX_W'(BEATS - 1));

endmodule
`default_nettype wire

// File: rtl/burst_line_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : burst_line_adaptor
// Brief    : Converts LLC line reads/writes into BEATS memory bursts.
//            Define BLA_WRAP_EN for critical-word-first beat ordering.
// Revision : 1.0
// ============================================================================
module burst_line_adaptor
    import bla_pkg::*;
#(
    parameter int LINE_W  = DEF_LINE_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LINE_W-1:0]  line_i,
    output logic [LINE_W-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int BEATS  = LINE_W / BURST_W;
    localparam int IDX_W  = $clog2(BEATS);
    localparam int OFF_LO = $clog2(BURST_W / 8);

    bla_state_e                    r_state;
    bla_state_e                    w_state_nxt;
    logic [31:0]                   r_addr;
    logic [BEATS-1:0][BURST_W-1:0] r_buf;
    logic [BEATS-1:0][BURST_W-1:0] r_line;
    logic [BEATS-1:0][BURST_W-1:0] w_merged;
    logic [IDX_W-1:0]              w_idx;
    logic [IDX_W-1:0]              w_start_idx;
    logic                          w_last;
    logic                          w_start;
    logic                          w_busy;
    logic                          w_adv;

`ifdef BLA_WRAP_EN
    assign w_start_idx = address_i[OFF_LO +: IDX_W];
`else
    assign w_start_idx = '0;
`endif

    assign w_start = (r_state == ST_IDLE) && (read_i || write_i);
    assign w_busy  = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_adv   = w_busy && resp_i;

    bla_beat_ctr #(
        .BEATS (BEATS),
        .IDX_W (IDX_W)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .start_idx (w_start_idx),
        .advance   (w_adv),
        .idx       (w_idx),
        .last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        read_o      = 1'b0;
        write_o     = 1'b0;
        resp_o      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (read_i) begin
                    w_state_nxt = ST_RD;
                end else if (write_i) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_RD: begin
                read_o = 1'b1;
                if (resp_i && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WR: begin
                write_o = 1'b1;
                if (resp_i && w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                resp_o      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_merged        = r_buf;
        w_merged[w_idx] = burst_i;
    end

    // r_buf assembles reads / holds the write line; r_line is only updated on
    // the final read beat so line_o stays stable across later transactions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_buf  <= '0;
            r_line <= '0;
        end else if (w_start) begin
            r_addr <= address_i;
            if (!read_i) begin
                r_buf <= line_i;
            end
        end else if ((r_state == ST_RD) && resp_i) begin
            r_buf <= w_merged;
            if (w_last) begin
                r_line <= w_merged;
            end
        end
    end

    assign address_o = w_busy ? r_addr : '0;
    assign burst_o   = (r_state == ST_WR) ? r_buf[w_idx] : '0;
    assign line_o    = r_line;

endmodule
`default_nettype wire

// File: tb/tb_burst_line_adaptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_burst_line_adaptor
// Brief    : Self-checking bench: transaction-level model plus directed reads,
//            writes, stalls, collisions, mid-flight reset and a 128/32 build.
// Revision : 1.0
// ============================================================================
module tb_burst_line_adaptor;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int OFF_LO  = $clog2(BURST_W / 8);
`ifdef BLA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [BURST_W-1:0] burst_i;
    logic [BURST_W-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    logic [127:0] b_line_i, b_line_o;
    logic [31:0]  b_address_i, b_address_o;
    logic         b_read_i, b_write_i, b_resp_o, b_read_o, b_write_o, b_resp_i;
    logic [31:0]  b_burst_i, b_burst_o;

    burst_line_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i),
        .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o),
        .resp_i(resp_i)
    );

    burst_line_adaptor #(.LINE_W(128), .BURST_W(32)) dut_small (
        .clk(clk), .rst(rst), .line_i(b_line_i), .line_o(b_line_o),
        .address_i(b_address_i), .read_i(b_read_i), .write_i(b_write_i),
        .resp_o(b_resp_o), .burst_i(b_burst_i), .burst_o(b_burst_o),
        .address_o(b_address_o), .read_o(b_read_o), .write_o(b_write_o),
        .resp_i(b_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;
    int wr_seen = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: mode 0 idle, 1 read, 2 write, 3 complete.
    int           m_mode  = 0;
    int           m_acks  = 0;
    int           m_first = 0;
    logic [31:0]  m_addr  = '0;
    logic [255:0] m_wline = '0;
    logic [255:0] m_asm   = '0;
    logic [255:0] m_line  = '0;

    always @(posedge clk) begin
        int slot;
        if (rst) begin
            m_mode = 0; m_acks = 0; m_addr = '0;
            m_asm = '0; m_line = '0; m_wline = '0;
        end else begin
            case (m_mode)
                0: if (read_i || write_i) begin
                    m_mode  = read_i ? 1 : 2;
                    m_addr  = address_i;
                    m_acks  = 0;
                    m_first = WRAP ? int'((address_i >> OFF_LO) % BEATS) : 0;
                    if (!read_i) m_wline = line_i;
                end
                1: if (resp_i) begin
                    slot = (m_first + m_acks) % BEATS;
                    m_asm[slot*BURST_W +: BURST_W] = burst_i;
                    m_acks++;
                    if (m_acks == BEATS) begin
                        m_mode = 3;
                        m_line = m_asm;
                    end
                end
                2: if (resp_i) begin
                    m_acks++;
                    if (m_acks == BEATS) m_mode = 3;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int es;
        if (chk_on) begin
            es = (m_first + m_acks) % BEATS;
            chk("read_o",    256'(read_o),    256'(m_mode == 1));
            chk("write_o",   256'(write_o),   256'(m_mode == 2));
            chk("resp_o",    256'(resp_o),    256'(m_mode == 3));
            chk("address_o", 256'(address_o), (m_mode == 1 || m_mode == 2) ? 256'(m_addr) : 256'd0);
            chk("burst_o",   256'(burst_o),   (m_mode == 2) ? 256'(m_wline[es*BURST_W +: BURST_W]) : 256'd0);
            chk("line_o",    line_o,          m_line);
            if (write_o) wr_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request in cycle 1, then BEATS acknowledged beats (optional stall before
    // beat stall_at), then the completion cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [255:0] wl, input logic [3:0][63:0] beats,
                           input int stall_at, input int stall_len,
                           input bit pin_en, input logic [3:0][63:0] pin);
        read_i = rd; write_i = wr; address_i = a; line_i = wl;
        tick();
        read_i = 1'b0; write_i = 1'b0; address_i = 32'hFFFF_FFFF; line_i = '1;
        for (int k = 0; k < BEATS; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    resp_i = 1'b0;
                    burst_i = {$urandom, $urandom};
                    tick();
                end
            end
            resp_i = 1'b1;
            burst_i = beats[k];
            if (pin_en) begin
                @(negedge clk);
                chk("burst_o_pin", 256'(burst_o), 256'(pin[k]));
            end
            tick();
        end
        resp_i = 1'b0;
        burst_i = '0;
        @(negedge clk);
        chk("resp_o_done", 256'(resp_o), 256'd1);
        tick();
    endtask

    logic [3:0][63:0] bt;
    logic [3:0][63:0] wl;
    logic [255:0]     exp_line;
    logic [127:0]     exp_small;

    initial begin
        rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
        burst_i = '0; resp_i = 1'b0;
        b_line_i = '0; b_address_i = '0; b_read_i = 1'b0; b_write_i = 1'b0;
        b_burst_i = '0; b_resp_i = 1'b0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_read_o",    256'(read_o),    256'd0);
        chk("rst_address_o", 256'(address_o), 256'd0);
        chk("rst_line_o",    line_o,          256'd0);
        tick();

        // Plain read; resp_o lands in cycle 6 counting the request cycle as 1.
        bt = {64'h4444444444444444, 64'h3333333333333333,
              64'h2222222222222222, 64'h1111111111111111};
        run_txn(1'b1, 1'b0, 32'h100, '0, bt, -1, 0, 1'b0, '0);
        chk("rd1_line", line_o, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

        // Write with a one-cycle gap before beat 2; slots presented in order.
        wl = {64'h0123456789ABCDEF, 64'h89ABCDEF01234567,
              64'hFEDCBA9876543210, 64'h76543210FEDCBA98};
        run_txn(1'b0, 1'b1, 32'h40, wl, '0, 2, 1, 1'b1, wl);
        chk("wr_keeps_line", line_o, 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

        // Read with a 3-cycle stall between the second and third beats.
        bt = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
              64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        run_txn(1'b1, 1'b0, 32'h200, '0, bt, 2, 3, 1'b0, '0);
        chk("stall_line", line_o, 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA);

        // Read and write together: read wins, write_o never seen.
        wr_seen = 0;
        bt = {64'h0000000000000008, 64'h0000000000000007,
              64'h0000000000000006, 64'h0000000000000005};
        run_txn(1'b1, 1'b1, 32'h300, {4{64'hEEEE_EEEE_EEEE_EEEE}}, bt, -1, 0, 1'b0, '0);
        chk("collide_no_write", 256'(wr_seen), 256'd0);
        chk("collide_line", line_o, 256'h0000000000000008_0000000000000007_0000000000000006_0000000000000005);

        // Reset after two beats of a read; late resp_i must be ignored.
        read_i = 1'b1; address_i = 32'h500;
        tick();
        read_i = 1'b0;
        resp_i = 1'b1; burst_i = 64'h9999999999999999;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_read_o",  256'(read_o),  256'd0);
        chk("abort_resp_o",  256'(resp_o),  256'd0);
        chk("abort_line_o",  line_o,        256'd0);
        chk("abort_addr_o",  256'(address_o), 256'd0);
        tick();
        tick();
        resp_i = 1'b0; burst_i = '0;
        tick();
        bt = {64'h0F0F0F0F0F0F0F0F, 64'h0E0E0E0E0E0E0E0E,
              64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C};
        run_txn(1'b1, 1'b0, 32'h600, '0, bt, -1, 0, 1'b0, '0);
        chk("post_rst_line", line_o, 256'h0F0F0F0F0F0F0F0F_0E0E0E0E0E0E0E0E_0D0D0D0D0D0D0D0D_0C0C0C0C0C0C0C0C);

        // Offset address 0x110: beat index field is 2.
        bt = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2,
              64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
        run_txn(1'b1, 1'b0, 32'h110, '0, bt, -1, 0, 1'b0, '0);
`ifdef BLA_WRAP_EN
        exp_line = 256'hD1D1D1D1D1D1D1D1_D0D0D0D0D0D0D0D0_D3D3D3D3D3D3D3D3_D2D2D2D2D2D2D2D2;
`else
        exp_line = 256'hD3D3D3D3D3D3D3D3_D2D2D2D2D2D2D2D2_D1D1D1D1D1D1D1D1_D0D0D0D0D0D0D0D0;
`endif
        chk("offset_line", line_o, exp_line);

        // 128/32 build: read at 0x08 (beat index field 2).
        b_read_i = 1'b1; b_address_i = 32'h8;
        tick();
        b_read_i = 1'b0; b_address_i = '0;
        for (int k = 0; k < 4; k++) begin
            b_resp_i = 1'b1;
            b_burst_i = 32'hA0A0A0A0 + 32'(k) * 32'h01010101;
            @(negedge clk);
            chk("small_read_o", 256'(b_read_o), 256'd1);
            chk("small_addr_o", 256'(b_address_o), 256'h8);
            tick();
        end
        b_resp_i = 1'b0; b_burst_i = '0;
        @(negedge clk);
        chk("small_resp_o", 256'(b_resp_o), 256'd1);
        tick();
`ifdef BLA_WRAP_EN
        exp_small = 128'hA1A1A1A1_A0A0A0A0_A3A3A3A3_A2A2A2A2;
`else
        exp_small = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
`endif
        chk("small_line", 256'(b_line_o), 256'(exp_small));
        chk("small_resp_gone", 256'(b_resp_o), 256'd0);

        tick();
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/burst_line_adaptor.md
BURST_LINE_ADAPTOR -- requirements
Module: burst_line_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, memory beat width in bits; LINE_W SHALL be an integer multiple of BURST_W, and BEATS = LINE_W/BURST_W SHALL be a power of two >= 2.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port line_i  input  LINE_W  write line from the LLC.
REQ-006 SHALL have port line_o  output  LINE_W  read line to the LLC.
REQ-007 SHALL have port address_i  input  32  line address from the LLC.
REQ-008 SHALL have port read_i / write_i  input  1 each  LLC request strobes.
REQ-009 SHALL have port resp_o  output  1  transaction-complete pulse to the LLC.
REQ-010 SHALL have port burst_i  input  BURST_W  read beat from memory.
REQ-011 SHALL have port burst_o  output  BURST_W  write beat to memory.
REQ-012 SHALL have port address_o  output  32  latched address to memory.
REQ-013 SHALL have port read_o / write_o  output  1 each  memory request strobes.
REQ-014 SHALL have port resp_i  input  1  memory beat acknowledge.

Function
REQ-015 SHALL implement the states IDLE, RD, WR and DONE.
REQ-016 In IDLE, read_i SHALL latch address_i, clear the beat counter and move to RD on the next edge; write_i SHALL also latch line_i and move to WR.
REQ-017 If read_i and write_i are both high in IDLE, read SHALL win and the write SHALL be dropped.
REQ-018 read_o SHALL be high in every RD cycle, write_o in every WR cycle, and both SHALL be low elsewhere.
REQ-019 address_o SHALL equal the latched address whenever read_o or write_o is high, and 0 otherwise.
REQ-020 In RD, each cycle with resp_i high SHALL store burst_i into line slot [BURST_W*beat +: BURST_W] and advance the beat counter modulo BEATS.
REQ-021 In WR, burst_o SHALL present latched slot [BURST_W*beat] combinationally, and each cycle with resp_i high SHALL advance the beat counter.
REQ-022 resp_i low SHALL stall the beat counter; gaps of any length between beats SHALL be tolerated.
REQ-023 After the BEATS-th acknowledged beat, the FSM SHALL move to DONE; resp_o SHALL be high for exactly one cycle in DONE, and the FSM SHALL then return to IDLE.
REQ-024 line_o SHALL present the assembled line during DONE and hold it until the next read reaches DONE; write transactions SHALL NOT change line_o.
REQ-025 read_i/write_i outside IDLE, and resp_i in IDLE or DONE, SHALL be ignored.
REQ-026 Minimum transaction latency SHALL be BEATS+2 cycles from the request edge to resp_o.

Reset
REQ-027 rst SHALL force IDLE, beat counter 0, line buffer 0 and latched address 0, so that read_o, write_o, resp_o, address_o, burst_o and line_o are all 0 on the next cycle.
REQ-028 rst asserted mid-transaction SHALL abort it with no resp_o; a resp_i arriving afterwards SHALL be ignored.

Configuration
REQ-029 Macro BLA_WRAP_EN, when defined, SHALL enable critical-word-first ordering.
- The first beat index SHALL be address_i bits [log2(LINE_W/8)-1 : log2(BURST_W/8)].
- The index SHALL increment modulo BEATS.
- The transaction SHALL complete after BEATS beats.
REQ-030 Without BLA_WRAP_EN, the first beat index SHALL be 0, and address_i offset bits SHALL pass to address_o unchanged but not affect ordering.

Structure
REQ-031 Package bla_pkg SHALL hold the FSM state enum and the default LINE_W/BURST_W constants.
REQ-032 Sub-module bla_beat_ctr SHALL hold the start/advance/terminal-count beat counter, including the wrap start index.

Verification
REQ-033 Read: with defaults, read_i at address 0x100 and beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> line_o = {0x44..,0x33..,0x22..,0x11..} and a single resp_o at cycle 6.
REQ-034 Write: line_i = 256'h0123...CDEF at address 0x40 -> burst_o shows slots 0..3 in order, each held until its resp_i, then resp_o.
REQ-035 Stall: resp_i low for 3 cycles between beats 1 and 2 -> beat counter holds, read_o stays high, final line is correct.
REQ-036 Simultaneous read_i and write_i in IDLE -> read_o only, write_o never asserts.
REQ-037 rst after beat 2 of a read -> all outputs 0 on the next cycle with no resp_o, and a following clean read completes normally.
REQ-038 With BLA_WRAP_EN, a read at address 0x110 -> beats fill slots 2, 3, 0, 1; BURST_W=32, LINE_W=128 regression also passes.
